// File: rtl/urt_rx_pkg.sv
// Shared definitions for the UART receive controller: FSM state encoding,
// legal oversampling ratios and parity type encoding.
package urt_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } par_type_e;

    localparam int PRESCALE_8     = 8;
    localparam int PRESCALE_16    = 16;
    localparam int EDGE_CNT_WIDTH = 4;

endpackage

// File: rtl/urt_rx_ctrl_if.sv
// Signal bundle between the receive controller and its line/sampler side;
// master is the controller view, slave is the sampler/consumer view.
interface urt_rx_ctrl_if #(
    parameter int PRESCALE_WIDTH = 5,
    parameter int DATA_WIDTH     = 8
) ();

    logic                                  rx_in;
    logic [PRESCALE_WIDTH-1:0]             prescale;
    logic                                  par_en;
    logic                                  par_typ;
    logic                                  sampled_bit;
    logic                                  dat_samp_en;
    logic [urt_rx_pkg::EDGE_CNT_WIDTH-1:0] edge_cnt;
    logic [DATA_WIDTH-1:0]                 p_data;
    logic                                  data_valid;
    logic                                  par_err;
    logic                                  stp_err;

    modport master (
        input  rx_in, prescale, par_en, par_typ, sampled_bit,
        output dat_samp_en, edge_cnt, p_data, data_valid, par_err, stp_err
    );

    modport slave (
        output rx_in, prescale, par_en, par_typ, sampled_bit,
        input  dat_samp_en, edge_cnt, p_data, data_valid, par_err, stp_err
    );

endinterface

// File: rtl/edge_bit_cnt_urt_rx.sv
// Oversample edge counter and received-bit counter; flags the last edge
// of each bit period while a frame is in progress.
module edge_bit_cnt_urt_rx
    import urt_rx_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 5,
    parameter int BIT_CNT_WIDTH  = 4
) (
    input  logic                      CLK_CTRL,
    input  logic                      RST_CTRL,
    input  logic                      cnt_active,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      bit_clr,
    input  logic                      bit_inc,
    output logic [EDGE_CNT_WIDTH-1:0] edge_cnt,
    output logic                      bit_end,
    output logic [BIT_CNT_WIDTH-1:0]  bit_cnt
);

    logic [PRESCALE_WIDTH-1:0] edge_last;

    assign edge_last = prescale - PRESCALE_WIDTH'(1);
    assign bit_end   = cnt_active && (PRESCALE_WIDTH'(edge_cnt) == edge_last);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge CLK_CTRL) begin
        if (RST_CTRL || !cnt_active || bit_end) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + EDGE_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK_CTRL) begin
        if (RST_CTRL || bit_clr) begin
            bit_cnt <= '0;
        end else if (bit_inc) begin
            bit_cnt <= bit_cnt + BIT_CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/urt_rx_ctrl.sv
// UART receive controller: frame FSM, LSB-first deserializer and parity/stop
// checks; frame settings are captured when a start bit is seen.
module urt_rx_ctrl
    import urt_rx_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 5,
    parameter int DATA_WIDTH     = 8
) (
    input  logic                      CLK_CTRL,
    input  logic                      RST_CTRL,
    input  logic                      RX_IN_CTRL,
    input  logic [PRESCALE_WIDTH-1:0] Prescale_CTRL,
    input  logic                      PAR_EN_CTRL,
    input  logic                      PAR_TYP_CTRL,
    input  logic                      sampled_bit_CTRL,
    output logic                      dat_samp_en_CTRL,
    output logic [EDGE_CNT_WIDTH-1:0] edge_cnt_CTRL,
    output logic [DATA_WIDTH-1:0]     P_DATA_CTRL,
    output logic                      data_valid_CTRL,
    output logic                      par_err_CTRL,
    output logic                      stp_err_CTRL
);

    localparam int BIT_CNT_WIDTH = $clog2(DATA_WIDTH + 1);

    rx_state_e                 state_q;
    rx_state_e                 state_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic                      par_en_q;
    par_type_e                 par_typ_q;
    logic                      bit_end;
    logic [BIT_CNT_WIDTH-1:0]  bit_cnt;

    logic frame_start;
    logic start_ok;
    logic data_shift;
    logic last_data_bit;
    logic parity_chk;
    logic stop_chk;
    logic par_err_d;

    assign frame_start   = (state_q == IDLE) && !RX_IN_CTRL;
    assign start_ok      = (state_q == START) && bit_end && !sampled_bit_CTRL;
    assign data_shift    = (state_q == DATA) && bit_end;
    assign last_data_bit = (bit_cnt == BIT_CNT_WIDTH'(DATA_WIDTH - 1));
    assign parity_chk    = (state_q == PARITY) && bit_end;
    assign stop_chk      = (state_q == STOP) && bit_end;
    assign par_err_d     = sampled_bit_CTRL != ((^P_DATA_CTRL) ^ (par_typ_q == PAR_ODD));

    edge_bit_cnt_urt_rx #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH),
        .BIT_CNT_WIDTH  (BIT_CNT_WIDTH)
    ) u_cnt (
        .CLK_CTRL   (CLK_CTRL),
        .RST_CTRL   (RST_CTRL),
        .cnt_active (state_q != IDLE),
        .prescale   (prescale_q),
        .bit_clr    (start_ok),
        .bit_inc    (data_shift),
        .edge_cnt   (edge_cnt_CTRL),
        .bit_end    (bit_end),
        .bit_cnt    (bit_cnt)
    );

    always_ff @(posedge CLK_CTRL) begin
        if (RST_CTRL) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: next state gets its default before the case so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!RX_IN_CTRL) state_d = START;
            START:   if (bit_end) state_d = sampled_bit_CTRL ? IDLE : DATA;
            DATA:    if (bit_end && last_data_bit) state_d = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end) state_d = STOP;
            STOP:    if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_CTRL) begin
        if (RST_CTRL) begin
            prescale_q       <= PRESCALE_WIDTH'(PRESCALE_8);
            par_en_q         <= 1'b0;
            par_typ_q        <= PAR_EVEN;
            dat_samp_en_CTRL <= 1'b0;
            P_DATA_CTRL      <= '0;
            data_valid_CTRL  <= 1'b0;
            par_err_CTRL     <= 1'b0;
            stp_err_CTRL     <= 1'b0;
        end else begin
            dat_samp_en_CTRL <= (state_d != IDLE);
            data_valid_CTRL  <= 1'b0;
            if (frame_start) begin
                prescale_q   <= Prescale_CTRL;
                par_en_q     <= PAR_EN_CTRL;
                par_typ_q    <= par_type_e'(PAR_TYP_CTRL);
                par_err_CTRL <= 1'b0;
                stp_err_CTRL <= 1'b0;
            end
            if (data_shift) begin
                P_DATA_CTRL <= {sampled_bit_CTRL, P_DATA_CTRL[DATA_WIDTH-1:1]};
            end
            if (parity_chk) begin
                par_err_CTRL <= par_err_d;
            end
            // Strobe only when this stop bit and the earlier parity check are both clean.
            if (stop_chk) begin
                stp_err_CTRL    <= !sampled_bit_CTRL;
                data_valid_CTRL <= sampled_bit_CTRL && !par_err_CTRL;
            end
        end
    end

endmodule

// File: tb/tb_urt_rx_ctrl.sv
// Bench for urt_rx_ctrl: directed and random frames compared every cycle
// against a frame-timeline model, plus literal timing/value expectations.
module tb_urt_rx_ctrl;
    import urt_rx_pkg::*;

    localparam int PW  = 5;
    localparam int DW  = 8;
    localparam int INF = 32'h7fff_ffff;

    logic CLK_CTRL = 1'b0;
    logic RST_CTRL;

    urt_rx_ctrl_if #(.PRESCALE_WIDTH(PW), .DATA_WIDTH(DW)) bus ();

    urt_rx_ctrl #(.PRESCALE_WIDTH(PW), .DATA_WIDTH(DW)) dut (
        .CLK_CTRL         (CLK_CTRL),
        .RST_CTRL         (RST_CTRL),
        .RX_IN_CTRL       (bus.rx_in),
        .Prescale_CTRL    (bus.prescale),
        .PAR_EN_CTRL      (bus.par_en),
        .PAR_TYP_CTRL     (bus.par_typ),
        .sampled_bit_CTRL (bus.sampled_bit),
        .dat_samp_en_CTRL (bus.dat_samp_en),
        .edge_cnt_CTRL    (bus.edge_cnt),
        .P_DATA_CTRL      (bus.p_data),
        .data_valid_CTRL  (bus.data_valid),
        .par_err_CTRL     (bus.par_err),
        .stp_err_CTRL     (bus.stp_err)
    );

    initial forever #5 CLK_CTRL = ~CLK_CTRL;

    int cyc = 0;
    always @(posedge CLK_CTRL) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK_CTRL);
        #1;
    endtask

    // Current frame as a timeline: start cycle, latched ratio, bits on the line.
    int            m_s = INF;
    int            m_p = PRESCALE_8;
    int            m_abort = 0;
    logic [DW-1:0] m_data = '0;
    logic          m_par_en = 1'b0, m_par_typ = 1'b0, m_par_bit = 1'b0;
    logic          m_stop_bit = 1'b1, m_glitch = 1'b0;
    logic [DW-1:0] base_pdata = '0;
    logic          base_par = 1'b0, base_stp = 1'b0;

    function automatic void model_at(input int c, output logic [DW-1:0] pd, output logic pe,
                                     output logic se, output logic dv, output logic en,
                                     output logic [3:0] ec);
        int n, len, k;
        pd = base_pdata; pe = base_par; se = base_stp; dv = 1'b0; en = 1'b0; ec = '0;
        if (c >= m_abort) begin
            pd = '0; pe = 1'b0; se = 1'b0;
            return;
        end
        if (c < m_s) return;
        n   = c - m_s;
        len = m_glitch ? m_p : (DW + 2 + int'(m_par_en)) * m_p;
        pe  = 1'b0;
        se  = 1'b0;
        if (n < len) begin
            en = 1'b1;
            ec = 4'(n % m_p);
        end
        if (m_glitch) return;
        k = n / m_p - 1;
        if (k < 0) k = 0;
        if (k > DW) k = DW;
        for (int j = 0; j < k; j++) pd = {m_data[j], pd[DW-1:1]};
        if (m_par_en && n >= (DW + 2) * m_p) pe = (m_par_bit != ((^m_data) ^ m_par_typ));
        if (n >= len) se = !m_stop_bit;
        dv = (n == len) && !pe && !se;
    endfunction

    logic [DW-1:0] e_pd;
    logic          e_pe, e_se, e_dv, e_en;
    logic [3:0]    e_ec;
    int            dv_count = 0;
    int            dv_cyc = -1;
    int            frame_s = 0;

    always @(negedge CLK_CTRL) begin
        if (cyc >= 1) begin
            model_at(cyc, e_pd, e_pe, e_se, e_dv, e_en, e_ec);
            check("p_data",      32'(bus.p_data),      32'(e_pd));
            check("par_err",     32'(bus.par_err),     32'(e_pe));
            check("stp_err",     32'(bus.stp_err),     32'(e_se));
            check("data_valid",  32'(bus.data_valid),  32'(e_dv));
            check("dat_samp_en", 32'(bus.dat_samp_en), 32'(e_en));
            check("edge_cnt",    32'(bus.edge_cnt),    32'(e_ec));
            if (bus.data_valid === 1'b1) begin
                dv_count++;
                dv_cyc = cyc;
            end
        end
    end

    // Called in an IDLE cycle; the start bit is seen at the end of it.
    task automatic send_frame(input logic [DW-1:0] data, input int p, input logic par_en,
                              input logic par_typ, input logic par_flip, input logic stop_bit,
                              input logic glitch, input int rst_after, input int sw_at,
                              input int sw_p);
        logic [DW+2:0] bits;
        int            nb;
        logic [DW-1:0] bpd;
        logic          bpe, bse, bdv, ben;
        logic [3:0]    bec;
        model_at(cyc, bpd, bpe, bse, bdv, ben, bec);
        base_pdata = bpd; base_par = bpe; base_stp = bse;
        m_s = cyc + 1; m_p = p; m_data = data; m_par_en = par_en; m_par_typ = par_typ;
        m_par_bit = (^data) ^ par_typ ^ par_flip; m_stop_bit = stop_bit; m_glitch = glitch;
        m_abort = INF;
        frame_s = m_s;
        bits = '0;
        for (int j = 0; j < DW; j++) bits[1+j] = data[j];
        if (par_en) begin
            bits[DW+1] = m_par_bit; bits[DW+2] = stop_bit; nb = DW + 3;
        end else begin
            bits[DW+1] = stop_bit; nb = DW + 2;
        end
        if (glitch) nb = 1;
        bus.rx_in = 1'b0; bus.prescale = PW'(p); bus.par_en = par_en; bus.par_typ = par_typ;
        bus.sampled_bit = glitch;
        tick();
        for (int n = 0; n < nb * p; n++) begin
            if (glitch) begin
                bus.rx_in = (n == 0) ? 1'b0 : 1'b1;
                bus.sampled_bit = 1'b1;
            end else begin
                bus.rx_in = bits[n/p];
                bus.sampled_bit = bits[n/p];
            end
            if (n == sw_at) begin
                bus.prescale = PW'(sw_p); bus.par_en = ~par_en; bus.par_typ = ~par_typ;
            end
            if (n == rst_after) begin
                RST_CTRL = 1'b1; bus.rx_in = 1'b1; m_abort = cyc + 1;
                tick();
                RST_CTRL = 1'b0;
                tick();
                return;
            end
            tick();
        end
        bus.rx_in = 1'b1; bus.sampled_bit = 1'b1;
        tick();
    endtask

    initial begin
        int n0, p, len;
        RST_CTRL = 1'b1; bus.rx_in = 1'b1; bus.sampled_bit = 1'b1;
        bus.prescale = PW'(PRESCALE_8); bus.par_en = 1'b0; bus.par_typ = 1'b0;
        repeat (3) tick();
        RST_CTRL = 1'b0;
        repeat (2) tick();
        check("reset_p_data", 32'(bus.p_data), 32'h0);
        check("reset_samp_en", 32'(bus.dat_samp_en), 32'h0);

        // 0xA5, Prescale 8, even parity (bit 0), good stop
        send_frame(8'hA5, PRESCALE_8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1, 0);
        check("even_par_dv_cycle", 32'(dv_cyc - frame_s), 32'd88);
        check("even_par_p_data", 32'(bus.p_data), 32'hA5);
        check("even_par_err", 32'(bus.par_err), 32'h0);

        // Same line bits but odd parity selected
        n0 = dv_count;
        send_frame(8'hA5, PRESCALE_8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, -1, -1, 0);
        check("odd_par_err", 32'(bus.par_err), 32'h1);
        check("odd_par_no_dv", 32'(dv_count), 32'(n0));
        check("odd_par_p_data", 32'(bus.p_data), 32'hA5);

        // Prescale 16, no parity, stop bit low
        n0 = dv_count;
        send_frame(8'h3C, PRESCALE_16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, 0);
        check("stop_err", 32'(bus.stp_err), 32'h1);
        check("stop_err_no_dv", 32'(dv_count), 32'(n0));
        check("stop_err_p_data", 32'(bus.p_data), 32'h3C);

        // Clean no-parity frame at Prescale 8
        send_frame(8'h96, PRESCALE_8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1, 0);
        check("nopar_dv_cycle", 32'(dv_cyc - frame_s), 32'd80);

        // Start-bit glitch
        n0 = dv_count;
        send_frame(8'h00, PRESCALE_8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1, 0);
        check("glitch_samp_en", 32'(bus.dat_samp_en), 32'h0);
        check("glitch_p_data", 32'(bus.p_data), 32'h96);
        check("glitch_flags", 32'({bus.par_err, bus.stp_err}), 32'h0);
        check("glitch_no_dv", 32'(dv_count), 32'(n0));

        // Reset during data bit 4, then a clean frame
        n0 = dv_count;
        send_frame(8'hC3, PRESCALE_8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5 * 8 + 3, -1, 0);
        check("rst_mid_p_data", 32'(bus.p_data), 32'h0);
        check("rst_mid_outputs", 32'({bus.dat_samp_en, bus.edge_cnt, bus.par_err, bus.stp_err}), 32'h0);
        check("rst_mid_no_dv", 32'(dv_count), 32'(n0));
        send_frame(8'h5A, PRESCALE_8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1, 0);
        check("after_rst_p_data", 32'(bus.p_data), 32'h5A);
        check("after_rst_dv", 32'(dv_count), 32'(n0 + 1));

        // Prescale switched 8->16 mid-frame, then a frame at 16
        send_frame(8'h81, PRESCALE_8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, 20, PRESCALE_16);
        check("switch_dv_cycle", 32'(dv_cyc - frame_s), 32'd80);
        send_frame(8'h42, PRESCALE_16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1, 0);
        check("p16_dv_cycle", 32'(dv_cyc - frame_s), 32'd160);
        check("p16_p_data", 32'(bus.p_data), 32'h42);

        // Random frames against the timeline model
        for (int i = 0; i < 40; i++) begin
            p   = ($urandom_range(0, 1) == 1) ? PRESCALE_16 : PRESCALE_8;
            len = (DW + 2) * p;
            send_frame(DW'($urandom), p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 9) == 0),
                       ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len - 1)) : -1,
                       ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1,
                       ($urandom_range(0, 1) == 1) ? PRESCALE_16 : PRESCALE_8);
            repeat ($urandom_range(0, 4)) tick();
        end

        repeat (4) tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
